// File: rtl/logip_pkg.sv
// rtl/logip_pkg.sv - shared trigger types, config field positions and limits
package logip_pkg;

  localparam int DLY_LSB   = 0;
  localparam int LVL_LSB   = 16;
  localparam int START_BIT = 27;

  localparam logic [1:0] MAX_LEVEL = 2'd3;

  typedef struct packed {
    logic [15:0] delay;
    logic [1:0]  level;
    logic        start;
  } trg_cfg_t;

  // Reset stage config: no delay, level 0, start set, so a default arm fires at once.
  localparam trg_cfg_t CFG_RESET = '{delay: 16'd0, level: 2'd0, start: 1'b1};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } trg_state_t;

endpackage

// File: rtl/trigger_if.sv
// rtl/trigger_if.sv - sample stream, config bus and trigger outputs of the trigger block
interface trigger_if #(
  parameter int CHLS = 32
);
  logic [CHLS-1:0] smpls_i;
  logic            stb_i;
  logic [1:0]      stg_i;
  logic            set_mask_i;
  logic            set_val_i;
  logic            set_cfg_i;
  logic [31:0]     cfg_data_i;
  logic            arm_i;
  logic [CHLS-1:0] smpls_o;
  logic            stb_o;
  logic            run_o;
  logic            armed_o;

  modport master (
    output smpls_i, stb_i, stg_i, set_mask_i, set_val_i, set_cfg_i, cfg_data_i, arm_i,
    input  smpls_o, stb_o, run_o, armed_o
  );

  modport slave (
    input  smpls_i, stb_i, stg_i, set_mask_i, set_val_i, set_cfg_i, cfg_data_i, arm_i,
    output smpls_o, stb_o, run_o, armed_o
  );
endinterface

// File: rtl/trg_stage.sv
// rtl/trg_stage.sv - one trigger stage: mask/value/config registers, match and delay counter
module trg_stage
  import logip_pkg::*;
#(
  parameter int CHLS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_mask_i,
  input  logic            wr_val_i,
  input  logic            wr_cfg_i,
  input  logic [CHLS-1:0] wdata_i,
  input  trg_cfg_t        wcfg_i,
  input  logic [CHLS-1:0] smpls_i,
  input  logic            eval_i,
  input  logic [1:0]      level_i,
  input  logic            clr_i,
  output logic            act_o,
  output logic            start_o
);

  logic [CHLS-1:0] mask;
  logic [CHLS-1:0] value;
  trg_cfg_t        cfg;
  logic [15:0]     cnt;
  logic            idle;
  logic            match;

  // A nonzero counter means a delayed action is pending; the stage ignores matches meanwhile.
  assign idle    = (cnt == 16'd0);
  assign match   = eval_i && (((smpls_i ^ value) & mask) == '0) && (cfg.level == level_i) && idle;
  assign act_o   = (match && (cfg.delay == 16'd0)) || (eval_i && (cnt == 16'd1));
  assign start_o = cfg.start;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask  <= '0;
      value <= '0;
      cfg   <= CFG_RESET;
      cnt   <= '0;
    end else begin
      if (wr_mask_i) mask  <= wdata_i;
      if (wr_val_i)  value <= wdata_i;
      if (wr_cfg_i)  cfg   <= wcfg_i;
      if (clr_i)
        cnt <= '0;
      else if (eval_i && !idle)
        cnt <= cnt - 16'd1;
      else if (match)
        cnt <= cfg.delay;
    end
  end

endmodule

// File: rtl/trigger.sv
// rtl/trigger.sv - SUMP-style multi-stage parallel trigger with one-cycle sample pass-through
module trigger
  import logip_pkg::*;
#(
  parameter int CHLS   = 32,
  parameter int STAGES = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  trigger_if.slave bus
);

  trg_state_t        state, state_nxt;
  logic [1:0]        level, level_nxt;
  logic [STAGES-1:0] act;
  logic [STAGES-1:0] start;
  logic              eval;
  logic              fire;
  logic              clr;
  trg_cfg_t          wcfg;

  assign wcfg.delay = bus.cfg_data_i[DLY_LSB +: 16];
  assign wcfg.level = bus.cfg_data_i[LVL_LSB +: 2];
  assign wcfg.start = bus.cfg_data_i[START_BIT];

  // A strobe coinciding with arm belongs to the old run and is not evaluated.
  assign eval = (state == ST_ARMED) && bus.stb_i && !bus.arm_i;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    trg_stage #(
      .CHLS(CHLS)
    ) u_stage (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_mask_i(bus.set_mask_i && (bus.stg_i == 2'(i))),
      .wr_val_i (bus.set_val_i && (bus.stg_i == 2'(i))),
      .wr_cfg_i (bus.set_cfg_i && (bus.stg_i == 2'(i))),
      .wdata_i  (bus.cfg_data_i[CHLS-1:0]),
      .wcfg_i   (wcfg),
      .smpls_i  (bus.smpls_i),
      .eval_i   (eval),
      .level_i  (level),
      .clr_i    (clr),
      .act_o    (act[i]),
      .start_o  (start[i])
    );
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    fire      = 1'b0;
    clr       = bus.arm_i;
    if (bus.arm_i) begin
      state_nxt = ST_ARMED;
      level_nxt = '0;
    end else if (state == ST_ARMED) begin
      if (|(act & start)) begin
        fire      = 1'b1;
        clr       = 1'b1;
        state_nxt = ST_IDLE;
        level_nxt = '0;
      end else if ((|act) && (level != MAX_LEVEL)) begin
        level_nxt = level + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      level       <= '0;
      bus.smpls_o <= '0;
      bus.stb_o   <= 1'b0;
      bus.run_o   <= 1'b0;
    end else begin
      state       <= state_nxt;
      level       <= level_nxt;
      bus.smpls_o <= bus.smpls_i;
      bus.stb_o   <= bus.stb_i;
      bus.run_o   <= fire;
    end
  end

  assign bus.armed_o = (state == ST_ARMED);

endmodule

// File: tb/tb_trigger.sv
// tb/tb_trigger.sv - directed and randomized checks of trigger against a reference model
module tb_trigger;

  localparam int CHLS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trigger_if #(.CHLS(CHLS)) tif ();

  trigger #(.CHLS(CHLS), .STAGES(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (tif.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] m_mask[4];
  logic [31:0] m_val[4];
  int          m_dly[4];
  int          m_lvl[4];
  bit          m_start[4];
  int          m_rem[4];
  int          m_level;
  bit          m_armed;
  logic [31:0] e_smpls;
  logic        e_stb;
  logic        e_run;
  int          n_runs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_mask[s] = '0; m_val[s] = '0; m_dly[s] = 0; m_lvl[s] = 0; m_start[s] = 1'b1; m_rem[s] = 0;
    end
    m_level = 0; m_armed = 1'b0; e_smpls = '0; e_stb = 1'b0; e_run = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently presented to the DUT.
  task automatic model_step();
    bit any_act, any_start;
    if (rst) begin
      model_reset();
      return;
    end
    e_smpls = tif.smpls_i;
    e_stb   = tif.stb_i;
    e_run   = 1'b0;
    if (tif.arm_i) begin
      m_armed = 1'b1;
      m_level = 0;
      for (int s = 0; s < 4; s++) m_rem[s] = 0;
    end else if (m_armed && tif.stb_i) begin
      any_act = 1'b0; any_start = 1'b0;
      for (int s = 0; s < 4; s++) begin
        bit fired = 1'b0;
        if (m_rem[s] > 0) begin
          m_rem[s]--;
          if (m_rem[s] == 0) fired = 1'b1;
        end else if (((tif.smpls_i ^ m_val[s]) & m_mask[s]) == 0 && m_lvl[s] == m_level) begin
          if (m_dly[s] == 0) fired = 1'b1;
          else m_rem[s] = m_dly[s];
        end
        if (fired) begin
          any_act = 1'b1;
          if (m_start[s]) any_start = 1'b1;
        end
      end
      if (any_start) begin
        e_run = 1'b1; m_armed = 1'b0; m_level = 0;
        for (int s = 0; s < 4; s++) m_rem[s] = 0;
      end else if (any_act && m_level < 3) begin
        m_level++;
      end
    end
    if (tif.set_mask_i) m_mask[tif.stg_i] = tif.cfg_data_i;
    if (tif.set_val_i)  m_val[tif.stg_i]  = tif.cfg_data_i;
    if (tif.set_cfg_i) begin
      m_dly[tif.stg_i]   = int'(tif.cfg_data_i[15:0]);
      m_lvl[tif.stg_i]   = int'(tif.cfg_data_i[17:16]);
      m_start[tif.stg_i] = tif.cfg_data_i[27];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("smpls_o", tif.smpls_o, e_smpls);
    chk("stb_o",   {31'd0, tif.stb_o},   {31'd0, e_stb});
    chk("run_o",   {31'd0, tif.run_o},   {31'd0, e_run});
    chk("armed_o", {31'd0, tif.armed_o}, {31'd0, m_armed});
    if (tif.run_o) n_runs++;
    tif.stb_i = 1'b0; tif.arm_i = 1'b0;
    tif.set_mask_i = 1'b0; tif.set_val_i = 1'b0; tif.set_cfg_i = 1'b0;
  endtask

  task automatic wr(input int stg, input int kind, input logic [31:0] data);
    tif.stg_i = 2'(stg);
    tif.cfg_data_i = data;
    tif.set_mask_i = (kind == 0);
    tif.set_val_i  = (kind == 1);
    tif.set_cfg_i  = (kind == 2);
    tick();
  endtask

  task automatic arm();
    tif.arm_i = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [31:0] d);
    tif.smpls_i = d;
    tif.stb_i = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    tif.smpls_i = '0; tif.stb_i = 1'b0; tif.stg_i = '0; tif.set_mask_i = 1'b0;
    tif.set_val_i = 1'b0; tif.set_cfg_i = 1'b0; tif.cfg_data_i = '0; tif.arm_i = 1'b0;
    n_runs = 0;
    model_reset();

    // Reset state
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("reset_armed", {31'd0, tif.armed_o}, 32'd0);

    // Default config fires on the first strobe after arm
    arm();
    chk("arm_armed", {31'd0, tif.armed_o}, 32'd1);
    strobe(32'hDEADBEEF);
    chk("dflt_smpls", tif.smpls_o, 32'hDEADBEEF);
    chk("dflt_run", {31'd0, tif.run_o}, 32'd1);
    chk("dflt_armed", {31'd0, tif.armed_o}, 32'd0);
    idle(1);
    chk("dflt_run_pulse", {31'd0, tif.run_o}, 32'd0);

    // Single-stage mask/value match
    wr(0, 0, 32'h0000_00FF);
    wr(0, 1, 32'h0000_0042);
    wr(0, 2, 32'h0800_0000);
    for (int s = 1; s < 4; s++) wr(s, 2, 32'h0003_0000);
    arm();
    strobe(32'h0000_0041);
    chk("mv_nomatch", {31'd0, tif.run_o}, 32'd0);
    strobe(32'h1234_5642);
    chk("mv_match", {31'd0, tif.run_o}, 32'd1);

    // Delay of 3 strobes with idle gaps
    wr(0, 2, 32'h0800_0003);
    arm();
    strobe(32'h0000_0042);
    chk("dly_n", {31'd0, tif.run_o}, 32'd0);
    idle(2);
    strobe(32'h0);
    chk("dly_n1", {31'd0, tif.run_o}, 32'd0);
    idle(1);
    strobe(32'h0);
    chk("dly_n2", {31'd0, tif.run_o}, 32'd0);
    idle(3);
    chk("dly_idle", {31'd0, tif.run_o}, 32'd0);
    strobe(32'h0);
    chk("dly_n3", {31'd0, tif.run_o}, 32'd1);

    // Two-level sequence
    wr(0, 0, 32'hF); wr(0, 1, 32'h1); wr(0, 2, 32'h0000_0000);
    wr(1, 0, 32'hF); wr(1, 1, 32'h2); wr(1, 2, 32'h0801_0000);
    arm();
    strobe(32'h2);
    chk("seq_wrong_order", {31'd0, tif.run_o}, 32'd0);
    strobe(32'h1);
    chk("seq_level1", {31'd0, tif.run_o}, 32'd0);
    strobe(32'h2);
    chk("seq_fire", {31'd0, tif.run_o}, 32'd1);
    arm();
    strobe(32'h1);
    arm();
    strobe(32'h2);
    chk("seq_rearm_lvl0", {31'd0, tif.run_o}, 32'd0);

    // Mask write coincident with strobe uses the old mask
    wr(0, 2, 32'h0800_0000);
    arm();
    tif.stg_i = 2'd0; tif.cfg_data_i = 32'h0; tif.set_mask_i = 1'b1;
    strobe(32'h5);
    chk("wr_same_cycle", {31'd0, tif.run_o}, 32'd0);
    strobe(32'h5);
    chk("wr_new_mask", {31'd0, tif.run_o}, 32'd1);

    // Arm coincident with a matching strobe
    tif.arm_i = 1'b1;
    strobe(32'h5);
    chk("arm_stb_norun", {31'd0, tif.run_o}, 32'd0);
    chk("arm_stb_armed", {31'd0, tif.armed_o}, 32'd1);
    strobe(32'h5);
    chk("arm_stb_next", {31'd0, tif.run_o}, 32'd1);

    // Reset during a long delay
    wr(0, 0, 32'hFF); wr(0, 1, 32'h42); wr(0, 2, 32'h0800_03E8);
    arm();
    strobe(32'h42);
    for (int i = 0; i < 5; i++) strobe(32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_smpls", tif.smpls_o, 32'h0);
    chk("rst_armed", {31'd0, tif.armed_o}, 32'd0);
    n_runs = 0;
    for (int i = 0; i < 20; i++) strobe(32'h42);
    chk("rst_no_run", n_runs, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        tif.stg_i = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 2))
          0: begin tif.cfg_data_i = $urandom & 32'h0000_000F; tif.set_mask_i = 1'b1; end
          1: begin tif.cfg_data_i = $urandom; tif.set_val_i = 1'b1; end
          default: begin
            tif.cfg_data_i = $urandom;
            tif.cfg_data_i[15:0] = 16'($urandom_range(0, 3));
            tif.cfg_data_i[27] = ($urandom_range(0, 2) == 0);
            tif.set_cfg_i = 1'b1;
          end
        endcase
      end
      tif.arm_i   = (!m_armed && $urandom_range(0, 5) == 0) || ($urandom_range(0, 80) == 0);
      tif.stb_i   = $urandom_range(0, 1);
      tif.smpls_i = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
